// File: rtl/reg_file_sb.sv
// Parametrised register file: two combinational read ports, one write port,
// and a per-register busy scoreboard driven by a reserve handshake.
module reg_file_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] RA1,
  input  logic [ADDR_WIDTH-1:0] RA2,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] RSV_A,
  input  logic                  reserve_enable,
  output logic                  reserve_ok
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  logic w_wr_ok;
  logic w_rsv_zero;

  assign w_wr_ok    = write_enable && !(ZR && (WA == '0));
  assign w_rsv_zero = ZR && (RSV_A == '0);

  // A busy target is still grantable when its result lands on the same edge.
  assign reserve_ok = !reset && reserve_enable &&
                      (w_rsv_zero || !r_busy[RSV_A] || (write_enable && (WA == RSV_A)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[WA]  <= data_in;
        r_busy[WA] <= 1'b0;
      end
      // Issued after the write so a same-address reservation keeps busy set.
      if (reserve_ok && !w_rsv_zero) r_busy[RSV_A] <= 1'b1;
    end
  end

  logic [1:0][ADDR_WIDTH-1:0] w_ra;
  logic [1:0][DATA_WIDTH-1:0] w_rd;
  logic [1:0]                 w_bsy;

  assign w_ra = {RA2, RA1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_rd[p] = r_mem[w_ra[p]];
      if (BP && w_wr_ok && (WA == w_ra[p])) w_rd[p] = data_in;
      if (ZR && (w_ra[p] == '0))            w_rd[p] = '0;
    end
    assign w_bsy[p] = r_busy[w_ra[p]];
  end

  assign data_out1 = w_rd[0];
  assign data_out2 = w_rd[1];
  assign busy1     = w_bsy[0];
  assign busy2     = w_bsy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three configurations share one stimulus stream and
// are scored against an array-based model of the register file rules.
module tb_reg_file_sb;
  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        rst, we, re;
  logic [4:0]  ra1, ra2, wa, rsv;
  logic [15:0] din;

  logic [15:0] do1 [3];
  logic [15:0] do2 [3];
  logic        b1 [3];
  logic        b2 [3];
  logic        rok [3];

  logic [7:0]  a_do1, a_do2, c_do1, c_do2;
  logic [15:0] b_do1, b_do2;

  // k=0: defaults; k=1: 16x32, no bypass; k=2: zero register with bypass
  reg_file_sb u_a (
    .clk(gclk), .reset(rst), .RA1(ra1[3:0]), .RA2(ra2[3:0]),
    .data_out1(a_do1), .data_out2(a_do2), .busy1(b1[0]), .busy2(b2[0]),
    .WA(wa[3:0]), .data_in(din[7:0]), .write_enable(we),
    .RSV_A(rsv[3:0]), .reserve_enable(re), .reserve_ok(rok[0]));

  reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(gclk), .reset(rst), .RA1(ra1), .RA2(ra2),
    .data_out1(b_do1), .data_out2(b_do2), .busy1(b1[1]), .busy2(b2[1]),
    .WA(wa), .data_in(din), .write_enable(we),
    .RSV_A(rsv), .reserve_enable(re), .reserve_ok(rok[1]));

  reg_file_sb #(.ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(gclk), .reset(rst), .RA1(ra1[3:0]), .RA2(ra2[3:0]),
    .data_out1(c_do1), .data_out2(c_do2), .busy1(b1[2]), .busy2(b2[2]),
    .WA(wa[3:0]), .data_in(din[7:0]), .write_enable(we),
    .RSV_A(rsv[3:0]), .reserve_enable(re), .reserve_ok(rok[2]));

  assign do1[0] = {8'h00, a_do1};
  assign do2[0] = {8'h00, a_do2};
  assign do1[1] = b_do1;
  assign do2[1] = b_do2;
  assign do1[2] = {8'h00, c_do1};
  assign do2[2] = {8'h00, c_do2};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [15:0] mem  [3][32];
  bit          busy [3][32];

  function automatic int aw(int k);  return (k == 1) ? 5 : 4; endfunction
  function automatic bit zr(int k);  return k == 2; endfunction
  function automatic bit bp(int k);  return k != 1; endfunction
  function automatic logic [4:0] am(int k, logic [4:0] a);
    return (k == 1) ? a : {1'b0, a[3:0]};
  endfunction
  function automatic logic [15:0] dm(int k, logic [15:0] d);
    return (k == 1) ? d : {8'h00, d[7:0]};
  endfunction

  function automatic logic [15:0] m_rd(int k, logic [4:0] ra);
    logic [4:0] a = am(k, ra);
    if (zr(k) && a == 0) return 16'h0;
    if (bp(k) && we && am(k, wa) == a) return dm(k, din);
    return mem[k][a];
  endfunction

  function automatic bit m_busy(int k, logic [4:0] ra);
    return busy[k][am(k, ra)];
  endfunction

  function automatic bit m_rok(int k);
    logic [4:0] r = am(k, rsv);
    if (rst || !re) return 1'b0;
    if (zr(k) && r == 0) return 1'b1;
    return !busy[k][r] || (we && am(k, wa) == r);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d_do1", k), do1[k], m_rd(k, ra1));
      chk($sformatf("k%0d_do2", k), do2[k], m_rd(k, ra2));
      chk($sformatf("k%0d_busy1", k), b1[k], m_busy(k, ra1));
      chk($sformatf("k%0d_busy2", k), b2[k], m_busy(k, ra2));
      chk($sformatf("k%0d_rok", k), rok[k], m_rok(k));
    end
  endtask

  task automatic model_update();
    bit ok [3];
    for (int k = 0; k < 3; k++) ok[k] = m_rok(k);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin mem[k][i] = '0; busy[k][i] = 1'b0; end
      end else begin
        if (we && !(zr(k) && am(k, wa) == 0)) begin
          mem[k][am(k, wa)]  = dm(k, din);
          busy[k][am(k, wa)] = 1'b0;
        end
        if (ok[k] && !(zr(k) && am(k, rsv) == 0)) busy[k][am(k, rsv)] = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [4:0] w_a, input logic [15:0] d,
                       input bit rv, input logic [4:0] rv_a,
                       input logic [4:0] a1, input logic [4:0] a2, input bit do_chk);
    @(negedge gclk);
    rst = r; we = w; wa = w_a; din = d; re = rv; rsv = rv_a; ra1 = a1; ra2 = a2;
    #1;
    if (do_chk) check_all();
  endtask

  task automatic tick();
    @(posedge gclk);
    model_update();
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; rsv = '0; ra1 = '0; ra2 = '0; din = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // reset state
    drive(0, 0, 0, 0, 0, 0, 4, 6, 1);
    for (int k = 0; k < 3; k++) begin
      chk("rst_do1", do1[k], 0); chk("rst_do2", do2[k], 0);
      chk("rst_b1", b1[k], 0);   chk("rst_b2", b2[k], 0);
    end
    tick();

    // write with bypass / without bypass
    drive(0, 1, 10, 32, 0, 0, 10, 0, 1);
    chk("byp_same", do1[0], 32); chk("nobyp_same", do1[1], 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 10, 0, 1);
    chk("wr_after", do1[0], 32); chk("wr_after_b", do1[1], 32);
    tick();

    // reserve handshake
    drive(0, 0, 0, 0, 1, 5, 0, 5, 1); chk("rsv_ok", rok[0], 1); tick();
    drive(0, 0, 0, 0, 1, 5, 0, 5, 1);
    chk("rsv_busy", b2[0], 1); chk("rsv_again", rok[0], 0);
    tick();
    drive(0, 1, 5, 77, 0, 0, 0, 5, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5, 1);
    chk("wr_clr_busy", b2[0], 0); chk("wr_clr_data", do2[0], 77);
    tick();

    // same-cycle write and reserve on a busy register
    drive(0, 0, 0, 0, 1, 5, 0, 0, 1); tick();
    drive(0, 1, 5, 9, 1, 5, 0, 0, 1); chk("wr_rsv_ok", rok[0], 1); tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0, 1);
    chk("wr_rsv_data", do1[0], 9); chk("wr_rsv_busy", b1[0], 1);
    tick();

    // zero register
    drive(0, 1, 0, 255, 0, 0, 0, 0, 1);
    chk("zr_byp", do1[2], 0); chk("nz_byp", do1[0], 255);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("zr_after", do1[2], 0); chk("nz_after", do1[0], 255);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1); chk("zr_rsv_ok", rok[2], 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("zr_busy", b1[2], 0); chk("nz_busy", b1[0], 1);
    tick();

    // wide config without bypass, then reset with a busy register
    drive(0, 1, 31, 16'hBEEF, 0, 0, 31, 0, 1); chk("b_old", do1[1], 0); tick();
    drive(0, 0, 0, 0, 1, 31, 31, 0, 1); chk("b_new", do1[1], 16'hBEEF); tick();
    drive(0, 0, 0, 0, 0, 0, 31, 0, 1); chk("b_busy", b1[1], 1); tick();
    drive(1, 1, 3, 16'h1234, 1, 7, 31, 0, 1); chk("rst_rok", rok[1], 0); tick();
    drive(0, 0, 0, 0, 0, 0, 31, 0, 1);
    chk("b_rst_data", do1[1], 0); chk("b_rst_busy", b1[1], 0);
    tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] w_a, r_a;
      w_a = 5'($urandom);
      r_a = ($urandom_range(0, 3) == 0) ? w_a : 5'($urandom);
      drive(($urandom_range(0, 49) == 0), 1'($urandom), w_a, 16'($urandom),
            1'($urandom), r_a,
            ($urandom_range(0, 2) == 0) ? w_a : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? r_a : 5'($urandom), 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with two asynchronous read ports, one synchronous write port and a per-register busy scoreboard. It succeeds the fixed 8-bit × 16 register file and adds:
- configurable width and depth;
- an optional hardwired-zero register 0;
- optional write-to-read bypass;
- a reserve handshake that marks a destination register busy until its result is written.

It sits between the datapath issue logic and the ALU write-back path.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH
- ZERO_REG, 0, 1 = register 0 always reads 0 and is never written, reserved or busy
- BYPASS, 1, 1 = a read of the address being written this cycle returns data_in

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; clears all registers and busy bits
- RA1  in  ADDR_WIDTH  read address, port 1
- RA2  in  ADDR_WIDTH  read address, port 2
- data_out1  out  DATA_WIDTH  read data, port 1
- data_out2  out  DATA_WIDTH  read data, port 2
- busy1  out  1  busy bit of register RA1
- busy2  out  1  busy bit of register RA2
- WA  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- write_enable  in  1  write data_in to WA at next edge
- RSV_A  in  ADDR_WIDTH  reserve address
- reserve_enable  in  1  request to mark RSV_A busy
- reserve_ok  out  1  reservation accepted this cycle

## Operation
- **Storage:** 2**ADDR_WIDTH registers of DATA_WIDTH bits plus one busy bit each.
- **Write:** write_enable=1 at a rising edge sets reg[WA] <= data_in and clears busy[WA]. A write to a non-busy register is legal and leaves busy at 0.
- **Reads:** data_outN = reg[RAN] combinationally.
  - If BYPASS=1, write_enable=1 and WA==RAN, data_outN = data_in.
  - Both ports may read the same address.
- **busyN:** busyN = busy[RAN], combinational, with no bypass of same-cycle reserve or write.
- **reserve_ok:** 1 when reserve_enable=1 and either busy[RSV_A]=0, or write_enable=1 with WA==RSV_A. Otherwise 0.
- **Accepted reservation:** busy[RSV_A] <= 1 at the edge. A rejected request changes nothing; the requester must retry.
- **Same-address write and reserve:** a write and an accepted reserve on the same address in the same cycle store the data and leave busy=1. The new reservation wins.
- **ZERO_REG=1:**
  - writes to address 0 are ignored;
  - reads of address 0 return 0, including under bypass;
  - busy[0] is always 0;
  - reserve of address 0 gives reserve_ok=1 with no effect.
- **Reset:** reset=1 at an edge clears all reg to 0 and all busy to 0. It overrides write_enable and reserve_enable in that cycle. reserve_ok is forced to 0 while reset=1.

## Timing
- **Read latency:** 0 cycles, combinational from RA, WA, data_in and write_enable.
- **Write visibility:**
  - BYPASS=1: visible in the same cycle.
  - BYPASS=0: visible from the cycle after the edge.
- **busy timing:**
  - busy set by reserve is visible on busyN from the cycle after the accepting edge.
  - busy cleared by write is visible from the cycle after the write edge.
- **Outputs after reset:** data_out1 = data_out2 = 0, busy1 = busy2 = 0, reserve_ok = 0 (unless a request is present after reset deasserts).
- **Reset mid-operation:** a reset asserted during outstanding reservations drops them all. Subsequent writes behave as writes to non-busy registers.
- **Undriven controls:** write_enable and reserve_enable must be 0 or 1. RA, WA and RSV_A are full range with no out-of-range case.

## Test plan
- **Reset:** reset for 1 cycle, then RA1=4, RA2=6 -> data_out1=0, data_out2=0, busy1=0, busy2=0.
- **Write and bypass (defaults):**
  - WA=10, data_in=32, write_enable=1, RA1=10 -> data_out1=32 in the same cycle.
  - After the edge, with write_enable=0 and RA1=10 -> data_out1=32.
- **Reserve:**
  - reserve_enable=1, RSV_A=5 -> reserve_ok=1; next cycle RA2=5 gives busy2=1.
  - A second reserve of 5 -> reserve_ok=0.
  - Write WA=5, data_in=77 -> next cycle busy2=0, data_out2=77.
- **Same-cycle write and reserve:** with reg 5 busy, WA=5, data_in=9 and RSV_A=5 in the same cycle -> reserve_ok=1; next cycle data_out=9, busy=1.
- **ZERO_REG=1 with BYPASS=1:** write WA=0, data_in=255 with RA1=0 -> data_out1=0 before and after the edge. Reserve of address 0 -> reserve_ok=1 and busy1 stays 0.
- **BYPASS=0 with DATA_WIDTH=16, ADDR_WIDTH=5:** write WA=31, data_in=16'hBEEF with RA1=31 -> old value 0 in the same cycle, 16'hBEEF after the edge. A reset with reg 31 busy clears data and busy.
